// File: rtl/writeback_unit.sv
// Writeback unit: buffers results in a 2-entry FIFO and retires them in order,
// either as a one-cycle register-write strobe or as a RAM write with ack/timeout.
module writeback_unit #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_to_reg,
  input  logic [2:0]        in_dest,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              reg_enable,
  output logic [2:0]        reg_select,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic              err_clr,
  output logic              err,
  output logic              busy
);

  typedef struct packed {
    logic              to_reg;
    logic [2:0]        dest;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REG_WR, RAM_WAIT} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  entry_t     mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  state_t     state, state_next;
  logic [7:0] timer, timer_next;
  logic       push, pop, timeout;
  entry_t     head;

  // Full is judged on the registered count alone, so a same-cycle pop never frees a slot.
  assign in_ready = (count < 2'd2);
  assign push     = in_valid & in_ready;
  assign head     = mem[rd_ptr];

  always_comb begin
    state_next = state;
    timer_next = timer;
    pop        = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (count != 2'd0) begin
          if (head.to_reg) begin
            state_next = REG_WR;
          end else begin
            state_next = RAM_WAIT;
            timer_next = '0;
          end
        end
      end
      REG_WR: begin
        pop        = 1'b1;
        state_next = IDLE;
      end
      RAM_WAIT: begin
        if (ram_ack) begin
          pop        = 1'b1;
          state_next = IDLE;
        end else if (timer == TIMER_LAST) begin
          timeout    = 1'b1;
          pop        = 1'b1;
          state_next = IDLE;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      err    <= 1'b0;
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      if (timeout) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{to_reg: in_to_reg, dest: in_dest, data: in_data, addr: in_addr};
    end
  end

  always_comb begin
    reg_enable = (state == REG_WR);
    ram_req    = (state == RAM_WAIT);
    reg_select = reg_enable ? head.dest : '0;
    reg_wdata  = reg_enable ? head.data : '0;
    ram_addr   = ram_req ? head.addr : '0;
    ram_wdata  = ram_req ? head.data : '0;
    busy       = (count != 2'd0) || (state != IDLE);
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the result data.
REQ-002 SHALL have parameter ADDR_W, default 8: width of the RAM address.
REQ-003 SHALL have parameter TIMEOUT, default 16, legal range 2..255: maximum RAM_WAIT cycles before the entry is abandoned.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream result valid.
REQ-008 in_ready  output  1  space is available (count<2).
REQ-009 in_to_reg  input  1  1 = register write, 0 = RAM write.
REQ-010 in_dest  input  3  destination register index.
REQ-011 in_data  input  DATA_W  result data.
REQ-012 in_addr  input  ADDR_W  RAM address; ignored when in_to_reg=1.
REQ-013 reg_enable  output  1  write strobe to the register-select decoder.
REQ-014 reg_select  output  3  register index to the decoder.
REQ-015 reg_wdata  output  DATA_W  register write data.
REQ-016 ram_req  output  1  RAM write request, level.
REQ-017 ram_addr  output  ADDR_W  RAM write address.
REQ-018 ram_wdata  output  DATA_W  RAM write data.
REQ-019 ram_ack  input  1  RAM write accepted.
REQ-020 err_clr  input  1  clears err.
REQ-021 err  output  1  sticky flag: a RAM write timed out.
REQ-022 busy  output  1  FIFO is non-empty or state is not IDLE.

Function
REQ-023 Input buffering SHALL use a 2-entry FIFO of {to_reg, dest, data, addr}.
REQ-024 The FIFO SHALL push at a rising edge when in_valid and in_ready are both 1.
REQ-025 in_ready SHALL be driven from registered count only, with no combinational path from in_valid, ram_ack or state; a full FIFO never accepts, even when a pop occurs in the same cycle.
REQ-026 Push and pop in the same cycle SHALL be legal when count=1, and count SHALL then stay 1.
REQ-027 The FSM SHALL have exactly three states: IDLE, REG_WR, RAM_WAIT.
REQ-028 In IDLE with count>0, the FSM SHALL go to REG_WR if head.to_reg=1, otherwise to RAM_WAIT with timer cleared to 0.
REQ-029 In IDLE with count=0, the FSM SHALL stay in IDLE.
REQ-030 REG_WR SHALL last exactly one cycle and then pop the head and return to IDLE.
REQ-031 In RAM_WAIT, if ram_ack=1 the FSM SHALL pop the head and go to IDLE; otherwise it SHALL increment timer.
REQ-032 In RAM_WAIT, when timer=TIMEOUT-1 and ram_ack=0, the FSM SHALL set err, pop (drop) the head and go to IDLE.
REQ-033 ram_ack in the timeout cycle SHALL win: normal completion, err unchanged.
REQ-034 Outputs SHALL be Moore: reg_enable = (state==REG_WR) and ram_req = (state==RAM_WAIT).
REQ-035 reg_select/reg_wdata and ram_addr/ram_wdata SHALL show the head entry while their strobe is high and SHALL be 0 otherwise.
REQ-036 Latency: entry pushed into an empty FIFO at edge E SHALL give reg_enable (or ram_req) high in the cycle starting at edge E+1.
REQ-037 Minimum spacing SHALL be 2 cycles per register write; a RAM write SHALL take 1..TIMEOUT cycles in RAM_WAIT plus 1 IDLE cycle.
REQ-038 ram_ack sampled while not in RAM_WAIT SHALL be ignored.
REQ-039 err_clr SHALL clear err; a timeout in the same cycle SHALL win, leaving err=1.
REQ-040 Entries SHALL complete in strict FIFO order regardless of type.

Reset
REQ-041 While reset=1 at an edge, the block SHALL empty the FIFO, set state to IDLE, timer to 0 and err to 0.
REQ-042 Reset SHALL make all outputs 0 except in_ready, which SHALL be 1.
REQ-043 Reset asserted during RAM_WAIT SHALL drop the request; ram_req SHALL be 0 in the cycle after the reset edge, and a late ram_ack SHALL be ignored.
REQ-044 Reset SHALL take priority over push, pop, err set and err_clr.

Verification
REQ-045 Push {to_reg=1, dest=5, data=8'hA7} into an empty FIFO -> next cycle reg_enable=1, reg_select=5, reg_wdata=8'hA7 for exactly 1 cycle, then busy=0.
REQ-046 Push RAM {addr=8'h3C, data=8'h55}, ack 3 cycles after ram_req rises -> ram_req high for exactly 4 cycles, err=0.
REQ-047 RAM write with ram_ack held 0, TIMEOUT=16 -> ram_req high for 16 cycles, err=1 and stays 1 until err_clr pulses.
REQ-048 Three back-to-back in_valid with a stalled RAM head -> in_ready=0 after 2 accepts; third accepted only after the pop; completion order is preserved.
REQ-049 Reset pulsed in the 2nd RAM_WAIT cycle -> next cycle ram_req=0, busy=0, in_ready=1; ram_ack pulsed afterwards has no effect.
REQ-050 ram_ack=1 exactly at timer=TIMEOUT-1 together with err_clr=1 -> normal pop, err=0.
